// File: rtl/icblbc_pkg.sv
// Shared definitions for the codes RAM arbiter: parameter defaults, FSM
// state encoding, requester index names and a one-hot decode helper.
package icblbc_pkg;

  localparam int NREQ_DEFAULT   = 3;
  localparam int AW_DEFAULT     = 11;
  localparam int DW_DEFAULT     = 8;
  localparam int RD_LAT_DEFAULT = 2;

  // Requester slots as wired at the system level.
  localparam int REQ_POPCAND = 0;
  localparam int REQ_ISO     = 1;
  localparam int REQ_HOST    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RR     = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // Index of the set bit of a one-hot vector (0 when the vector is empty).
  function automatic int unsigned oh2idx(input logic [31:0] oh);
    oh2idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) oh2idx = i;
    end
  endfunction

endpackage

// File: rtl/codes_ram_arbiter_if.sv
// Requester-side and RAM-side bus of the codes RAM arbiter. The master view
// belongs to the requesters plus the RAM, the slave view to the arbiter.
interface codes_ram_arbiter_if
  import icblbc_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int AW   = AW_DEFAULT,
  parameter int DW   = DW_DEFAULT
);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    lock;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic [AW-1:0]      ram_address;
  logic [DW-1:0]      ram_data;
  logic               ram_wren;
  logic [DW-1:0]      ram_q;

  modport master (
    output req, lock, we, addr, wdata, ram_q,
    input  gnt, rvalid, rdata, ram_address, ram_data, ram_wren
  );

  modport slave (
    input  req, lock, we, addr, wdata, ram_q,
    output gnt, rvalid, rdata, ram_address, ram_data, ram_wren
  );

endinterface

// File: rtl/codes_ram_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the one-hot first eligible
// requester at or after the search pointer, wrapping around.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_elig,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_win
);

  logic [2*NREQ-1:0] w_dbl;
  logic [2*NREQ-1:0] w_back;
  logic [NREQ-1:0]   w_rot;
  logic [NREQ-1:0]   w_pick;

  // Rotate so the pointer sits at bit 0, keep the lowest set bit, rotate back.
  always_comb begin
    w_dbl  = {i_elig, i_elig} >> i_ptr;
    w_rot  = w_dbl[NREQ-1:0];
    w_pick = w_rot & (~w_rot + NREQ'(1));
    w_back = {w_pick, w_pick} << i_ptr;
    o_win  = w_back[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/codes_ram_arbiter.sv
// Single-port RAM arbiter: one access per cycle, round-robin with an
// optional lock, registered RAM command and a read-return pipeline that
// routes ram_q back to the requester that issued the read.
module codes_ram_arbiter
  import icblbc_pkg::*;
#(
  parameter int NREQ   = NREQ_DEFAULT,
  parameter int AW     = AW_DEFAULT,
  parameter int DW     = DW_DEFAULT,
  parameter int RD_LAT = RD_LAT_DEFAULT
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic [AW-1:0]      ram_address,
  output logic [DW-1:0]      ram_data,
  output logic               ram_wren,
  input  logic [DW-1:0]      ram_q
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_arm;
  logic [NREQ-1:0]   r_gnt;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_last;
  logic [AW-1:0]     r_ram_addr;
  logic [DW-1:0]     r_ram_data;
  logic              r_ram_wren;
  logic [RD_LAT-1:0] r_rd_vld;
  logic [IDW-1:0]    r_rd_id [RD_LAT];
  logic [DW-1:0]     r_rdata;

  logic              w_lock_hold;
  logic [NREQ-1:0]   w_owner_oh;
  logic [NREQ-1:0]   w_elig;
  logic [NREQ-1:0]   w_win;
  logic              w_any;
  logic [IDW-1:0]    w_win_idx;
  logic [IDW-1:0]    w_ptr_nxt;

  // Eligibility: requesting and not granted this cycle; while the lock owner
  // keeps lock high, nobody else may compete. Nothing is eligible in the
  // first cycle after reset release.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    w_lock_hold = 1'b0;
    w_owner_oh  = '0;
    w_elig      = '0;
    w_lock_hold = (r_state == LOCKED) && lock[r_last];
    w_owner_oh  = NREQ'(1) << r_last;
    if (r_arm) begin
      w_elig = req & ~r_gnt;
      if (w_lock_hold) w_elig = w_elig & w_owner_oh;
    end
  end

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .i_elig (w_elig),
    .i_ptr  (r_ptr),
    .o_win  (w_win)
  );

  // Winner decode and the pointer that follows it.
  always_comb begin
    w_any     = |w_win;
    w_win_idx = IDW'(oh2idx(32'(w_win)));
    w_ptr_nxt = (w_win_idx == IDW'(NREQ - 1)) ? '0 : w_win_idx + IDW'(1);
  end

  // Next state: stay locked while the owner holds lock; otherwise the winner
  // (if any) decides between RR and LOCKED, and no winner means IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (w_lock_hold) begin
      w_state_nxt = LOCKED;
    end else if (w_any) begin
      w_state_nxt = lock[w_win_idx] ? LOCKED : RR;
    end else begin
      w_state_nxt = IDLE;
    end
  end

  // FSM state register plus the one-cycle arming flag after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_arm   <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // flop samples pre-edge values regardless of block ordering.
      r_state <= w_state_nxt;
      r_arm   <= 1'b1;
    end
  end

  // Grant, search pointer, last-granted index and the registered RAM command.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt      <= '0;
      r_ptr      <= '0;
      r_last     <= '0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_ram_wren <= 1'b0;
    end else begin
      r_gnt      <= w_win;
      r_ram_wren <= w_any && we[w_win_idx];
      if (w_any) begin
        r_ptr      <= w_ptr_nxt;
        r_last     <= w_win_idx;
        r_ram_addr <= addr[w_win_idx*AW +: AW];
        r_ram_data <= wdata[w_win_idx*DW +: DW];
      end
    end
  end

  // Read-return pipeline: a granted read enters stage 0 and leaves the last
  // stage exactly RD_LAT cycles after its grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_vld <= '0;
      for (int k = 0; k < RD_LAT; k++) r_rd_id[k] <= '0;
    end else begin
      r_rd_vld[0] <= (|r_gnt) && !r_ram_wren;
      r_rd_id[0]  <= r_last;
      for (int k = 1; k < RD_LAT; k++) begin
        r_rd_vld[k] <= r_rd_vld[k-1];
        r_rd_id[k]  <= r_rd_id[k-1];
      end
    end
  end

  // Holding copy of the last returned read data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (r_rd_vld[RD_LAT-1]) begin
      r_rdata <= ram_q;
    end
  end

  assign gnt         = r_gnt;
  assign ram_address = r_ram_addr;
  assign ram_data    = r_ram_data;
  assign ram_wren    = r_ram_wren;
  assign rvalid      = r_rd_vld[RD_LAT-1] ? (NREQ'(1) << r_rd_id[RD_LAT-1]) : '0;
  assign rdata       = r_rd_vld[RD_LAT-1] ? ram_q : r_rdata;

endmodule

// File: doc/codes_ram_arbiter.md
CODES_RAM_ARBITER -- requirements
Module: codes_ram_arbiter

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameters SHALL be:
- NREQ, default 3, number of requesters.
- AW, default 11, RAM address width.
- DW, default 8, RAM data width.
- RD_LAT, default 2, RAM read latency in cycles.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1, rising-edge clock.
- reset_n, in, 1, asynchronous active-low reset.
- req, in, NREQ, per-requester access request.
- lock, in, NREQ, keep the grant on this requester.
- we, in, NREQ, 1 = write, 0 = read.
- addr, in, NREQ*AW, packed addresses; requester i at [i*AW +: AW].
- wdata, in, NREQ*DW, packed write data.
- gnt, out, NREQ, one-hot, access accepted this cycle.
- rvalid, out, NREQ, one-hot, read data returned.
- rdata, out, DW, read data.
- ram_address, out, AW, single-port RAM address.
- ram_data, out, DW, RAM write data.
- ram_wren, out, 1, RAM write enable.
- ram_q, in, DW, RAM read data.

Function
REQ-004 The block SHALL issue at most one RAM access per cycle, and gnt SHALL be one-hot or zero.
REQ-005 Arbitration SHALL run in cycle t over eligible requesters: req[i]=1 and gnt[i]=0 in cycle t.
REQ-006 The winner of cycle t SHALL be granted in cycle t+1:
- gnt[winner]=1 for exactly one cycle.
- ram_address, ram_wren and ram_data SHALL be driven from registers holding addr, we and wdata of the winner as sampled in cycle t.
REQ-007 A requester SHALL hold req, we, addr and wdata stable until it sees gnt; the cycle after gnt it MAY present a new request.
REQ-008 A requester asserting req on consecutive cycles SHALL be granted at most every second cycle (gnt masks req per REQ-005); any other eligible requester SHALL be granted in the gap cycles.
REQ-009 The state machine SHALL have three states:
- IDLE: no grant in progress.
- RR: round-robin grant.
- LOCKED: grant held by the lock owner.
REQ-010 In IDLE or RR, the winner SHALL be the first eligible requester, searching from (last granted index + 1) mod NREQ; the search pointer after reset SHALL be 0.
REQ-011 When no requester is eligible, the state SHALL become IDLE, ram_wren SHALL be 0, and ram_address SHALL hold its last value.
REQ-012 When a requester is granted with lock[i]=1, the state SHALL become LOCKED, and only requester i SHALL be eligible while lock[i]=1.
REQ-013 When lock[i] falls, the state SHALL return to RR in the next cycle, with the search starting at i+1.
REQ-014 lock on a requester that is not currently granted SHALL be ignored until that requester wins normally.
REQ-015 A read granted in cycle g SHALL produce, in cycle g+RD_LAT:
- rvalid[i]=1 for exactly one cycle.
- rdata equal to ram_q.
REQ-016 Pending reads SHALL be tracked in a RD_LAT-deep pipeline of {valid, requester id}. Back-to-back reads SHALL return in grant order at one per cycle.
REQ-017 Writes SHALL produce no rvalid.
REQ-018 A write to address A granted in cycle g, followed by a read of A granted in cycle g+1 or later, SHALL return the written data.
REQ-019 Simultaneous rvalid[j] and gnt[i] in the same cycle SHALL both occur, including when i=j.
REQ-020 rdata SHALL hold its last value when rvalid is 0.

Reset
REQ-021 While reset_n=0, asynchronously, the block SHALL force:
- gnt=0, rvalid=0, ram_wren=0.
- ram_address=0, ram_data=0, rdata=0.
- state=IDLE, search pointer=0.
- read pipeline cleared.
REQ-022 Reads in flight at reset assertion SHALL be dropped; no rvalid SHALL appear for them after reset_n rises.
REQ-023 The first grant SHALL be possible in the second rising edge after reset_n rises.

Structure
REQ-024 The shared package icblbc_pkg SHALL hold:
- Defaults for NREQ, AW, DW, RD_LAT.
- The state encoding (IDLE, RR, LOCKED).
- Requester index constants: REQ_POPCAND=0, REQ_ISO=1, REQ_HOST=2.
REQ-025 A single sub-module, rr_pick, SHALL compute the combinational round-robin winner (one-hot) from the eligible vector and the search pointer. All other logic SHALL stay in codes_ram_arbiter.

Verification
REQ-026 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Read latency: req[0] read addr 0x005, RAM holding 0x1F at 0x005 -> gnt[0] next cycle; rvalid[0]=1 with rdata=0x1F exactly 2 cycles after gnt.
- Round-robin: req=3'b111 held continuously, all reads -> grant order 0,1,2,0,1,2; no requester starved; no cycle with two gnt bits.
- Read-after-write: req[2] write 0xA5 to 0x7FF, then req[1] read 0x7FF -> rvalid[1] with rdata=0xA5.
- Lock: requester 0 granted with lock[0]=1 for 6 cycles while req[1] is high -> gnt[1]=0 throughout; gnt[1]=1 within 2 cycles of lock[0] falling.
- Reset mid-read: reset_n pulsed low one cycle after a read grant -> all outputs 0 during reset; no rvalid afterwards; next grant goes to requester 0 first.
- Idle: req=0 for 10 cycles -> ram_wren=0, gnt=0, rvalid=0 throughout.
